// File: rtl/gsim_param_solver.sv
// gsim_param_solver: banded Gauss-Seidel solver for A*x = b, A = [-1 6 -13 20 -13 6 -1]
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_en, b_in         b-vector beats (index order), accepted while in_ready
//   iter_num            sweep count, sampled on beat 0 (0 runs one sweep)
//   in_ready            high while receiving
//   out_valid, out_ready, x_out   solution stream (index order) with backpressure
//   iter_cnt            sweeps actually run, held until the next frame
//
// Optional feature: define GSIM_EARLY_STOP_EN to stop sweeping once the largest
// per-sweep change of any x drops below TOL LSBs.
module gsim_param_solver #(
    parameter int N      = 16,
    parameter int B_W    = 16,
    parameter int X_W    = 32,
    parameter int FRAC   = 16,
    parameter int ITER_W = 8,
    parameter int TOL    = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_en,
    input  logic signed [B_W-1:0]    b_in,
    input  logic [ITER_W-1:0]        iter_num,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [X_W-1:0]    x_out,
    output logic [ITER_W-1:0]        iter_cnt
);
    localparam int KW = $clog2(N);
    localparam int IW = $clog2(N + 6);
    localparam int SW = X_W + 8;
    localparam int PW = X_W + 25;
    localparam logic signed [X_W-1:0] XMAX = {1'b0, {(X_W-1){1'b1}}};
    localparam logic signed [X_W-1:0] XMIN = {1'b1, {(X_W-1){1'b0}}};
    localparam logic signed [PW-1:0]  QMAX = PW'(XMAX);
    localparam logic signed [PW-1:0]  QMIN = PW'(XMIN);

    typedef enum logic [1:0] {RECEIVE, CALC, SEND} state_t;
    state_t state, state_nxt;

    logic [KW-1:0]         k, i;
    logic [ITER_W-1:0]     iter_tgt;
    logic signed [B_W-1:0] b [N];
    logic signed [X_W-1:0] x [N];
    logic signed [SW-1:0]  xe [N+6];
    logic [IW-1:0]         ie;
    logic signed [SW-1:0]  bs, s;
    logic signed [PW-1:0]  prod, q;
    logic signed [X_W-1:0] x_new;
    logic beat, last_beat, sweep_end, calc_done, last_send, early;

    assign in_ready  = state == RECEIVE;
    assign out_valid = state == SEND;
    assign beat      = in_ready && in_en;
    assign last_beat = beat && k == KW'(N - 1);
    assign sweep_end = state == CALC && i == KW'(N - 1);
    assign calc_done = sweep_end && (iter_cnt + ITER_W'(1) == iter_tgt || early);
    assign last_send = out_valid && out_ready && k == KW'(N - 1);
    assign x_out     = out_valid ? x[k] : '0;

    // x padded with three zeros on each side so edge rows need no special case;
    // xe[ie+3] is x[i].
    always_comb begin
        for (int j = 0; j < N + 6; j++) xe[j] = '0;
        for (int j = 0; j < N; j++) xe[j+3] = x[j];
        ie = IW'(i);
        bs = b[i];
        s = (bs <<< FRAC)
          + SW'(13) * (xe[ie + IW'(2)] + xe[ie + IW'(4)])
          - SW'(6)  * (xe[ie + IW'(1)] + xe[ie + IW'(5)])
          + xe[ie] + xe[ie + IW'(6)];
        // 52429 / 2^20 ~= 1/20, the reciprocal of the diagonal
        prod = PW'(s) * PW'(52429);
        q = prod >>> 20;
        x_new = q > QMAX ? XMAX : q < QMIN ? XMIN : q[X_W-1:0];
    end

`ifdef GSIM_EARLY_STOP_EN
    logic [X_W:0]        dmax, delta, dmax_sw;
    logic signed [X_W:0] diff, xn_e, xo_e;

    always_comb begin
        xn_e    = x_new;
        xo_e    = x[i];
        diff    = xn_e - xo_e;
        delta   = diff[X_W] ? $unsigned(-diff) : $unsigned(diff);
        dmax_sw = delta > dmax ? delta : dmax;
        early   = dmax_sw < (X_W+1)'(TOL);
    end

    always_ff @(posedge clk) begin
        if (reset)
            dmax <= '0;
        else if (state == CALC)
            dmax <= sweep_end ? '0 : dmax_sw;
    end
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= RECEIVE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = state == RECEIVE ? (last_beat ? CALC : RECEIVE)
                  : state == CALC    ? (calc_done ? SEND : CALC)
                  : state == SEND    ? (last_send ? RECEIVE : SEND)
                  : RECEIVE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k        <= '0;
            i        <= '0;
            iter_tgt <= '0;
            iter_cnt <= '0;
            for (int j = 0; j < N; j++) begin
                b[j] <= '0;
                x[j] <= '0;
            end
        end else begin
            if (beat) begin
                b[k] <= b_in;
                x[k] <= X_W'(b_in) <<< FRAC;
                k    <= last_beat ? '0 : k + KW'(1);
                if (k == '0) begin
                    iter_tgt <= iter_num == '0 ? ITER_W'(1) : iter_num;
                    iter_cnt <= '0;
                end
            end
            if (state == CALC) begin
                x[i] <= x_new;
                i    <= sweep_end ? '0 : i + KW'(1);
                if (sweep_end)
                    iter_cnt <= iter_cnt + ITER_W'(1);
            end
            if (out_valid && out_ready)
                k <= last_send ? '0 : k + KW'(1);
        end
    end
endmodule
